ctrl_unit_seq: RTL and testbench
================================

CTRL_UNIT_SEQ -- requirements
Module: ctrl_unit_seq

Interface
REQ-001 The block SHALL have parameter CMD_W, default 4: width of cmd_exe.
REQ-002 The block SHALL have parameter MUL_CYCLES, default 3: total MUL issue latency in cycles; legal range 2..15.
REQ-003 The block SHALL have parameter EN_MUL, default 1: 0 decodes MUL as undefined.
REQ-004 The block SHALL have these ports:
  clk  in  1  single clock; all state on rising edge
  rst  in  1  synchronous, active-high reset
  valid_in  in  1  instruction present
  mode  in  2  instruction class
  opcode  in  4  ALU or sub-operation
  s_in  in  1  S bit / load-store L bit
  freeze  in  1  SRAM wait; hold everything
  flush  in  1  branch taken; squash
  ready_out  out  1  block accepts valid_in this cycle
  valid_out  out  1  registered outputs carry a real instruction
  cmd_exe  out  CMD_W  execute command
  mem_r_en / mem_w_en / wb_en / b_out / s_out  out  1 each  registered controls
  undef_out  out  1  one-cycle pulse on undefined encoding
  mul_busy  out  1  multi-cycle MUL in progress

Function
REQ-005 The block SHALL register all outputs except ready_out; an accepted instruction appears on outputs 1 cycle after acceptance, except MUL.
REQ-006 Acceptance SHALL be defined as valid_in & ready_out & ~freeze & ~flush; ready_out = (state==IDLE).
REQ-007 Mode 00 SHALL decode as MOV 1101->1, ADD 0100->2, ADC 0101->3, SUB 0010->4, SBC 0110->5, AND 0000->6, ORR 1100->7, EOR 0001->8, MVN 1111->9, with wb_en=1 and s_out=s_in.
REQ-008 CMP 1010 and TST 1000 with s_in=1 SHALL produce cmd 4 and cmd 6 respectively, with s_out=1 and wb_en=0; with s_in=0 they SHALL produce a bubble (valid_out=1, all enables 0, cmd 0).
REQ-009 Any other mode-00 opcode SHALL produce cmd 0, all enables 0, s_out=0 and undef_out=1; the output is never high-impedance.
REQ-010 Mode 01 SHALL produce cmd 2; s_in=1 gives mem_r_en=1, wb_en=1 and s_out=1; s_in=0 gives mem_w_en=1 and s_out=0.
REQ-011 Mode 10 with opcode[3]=0 SHALL produce b_out=1; with opcode[3]=1 it SHALL produce a bubble.
REQ-012 Mode 11 with opcode 0000 and EN_MUL=1 SHALL be decoded as MUL: cmd 10, wb_en=1, s_out=s_in; every other mode-11 encoding SHALL be undefined as in REQ-009.
REQ-013 The FSM SHALL have two states, IDLE and MUL_BUSY, with a 4-bit down-counter cnt.
  - IDLE to MUL_BUSY on MUL acceptance; cnt loads MUL_CYCLES-2; outputs become a bubble with valid_out=0.
  - In MUL_BUSY, if cnt>0: cnt decrements; outputs hold the bubble.
  - In MUL_BUSY, if cnt==0: outputs load the MUL controls with valid_out=1; the FSM returns to IDLE.
  - The net result is that MUL controls appear MUL_CYCLES cycles after acceptance.
REQ-014 mul_busy SHALL be 1 exactly when state==MUL_BUSY.
REQ-015 With no acceptance in IDLE and no MUL completion, the next outputs SHALL be a bubble with valid_out=0.
REQ-016 Event priority SHALL be rst > flush > freeze > normal operation.
REQ-017 When freeze=1 and flush=0, all registers SHALL hold, including state, cnt and outputs; undef_out is held, not re-pulsed.
REQ-018 flush=1 SHALL produce a bubble with valid_out=0 on the next edge; it forces IDLE, aborts any MUL in progress, and the instruction on valid_in that cycle is not accepted.
REQ-019 The undefined-encoding case SHALL still count as accepted (valid_out=1, undef_out=1) so that the upstream stage advances.

Reset
REQ-020 On rst=1 at an edge: state=IDLE, cnt=0, and every registered output =0; ready_out SHALL read 1 in the cycle after reset.
REQ-021 Reset asserted during MUL_BUSY SHALL abandon the MUL; the MUL controls are never emitted.

Structure
REQ-022 The mode encodings, opcode encodings, cmd_exe codes (0..10) and FSM state encoding SHALL live in shared package arm_ctrl_pkg.
REQ-023 The purely combinational opcode-to-control decode SHALL be one sub-module, ctrl_decode; ctrl_unit_seq holds the FSM, counter and output registers.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
  - ADD with s_in=1 (mode 00, opcode 0100, valid_in=1) -> next cycle valid_out=1, cmd 2, wb_en=1, s_out=1.
  - CMP with s_in=0 -> valid_out=1, cmd 0, all enables 0; CMP with s_in=1 -> cmd 4, s_out=1, wb_en=0.
  - MUL with MUL_CYCLES=3 accepted at cycle T -> ready_out=0 and valid_out=0 at T+1 and T+2; cmd 10 with wb_en=1 at T+3; ready_out=1 at T+3.
  - LDR held by freeze=1 for 4 cycles -> outputs and mul_busy unchanged throughout; the pipeline resumes the cycle after freeze drops.
  - flush at T+1 of a MUL -> valid_out=0 at T+2, state IDLE, cmd 10 never appears.
  - Mode 00, opcode 0011 -> undef_out=1 for one cycle, cmd 0; rst mid-MUL -> all outputs 0 next cycle.

Source files
------------

// File: rtl/arm_ctrl_pkg.sv
// Shared encodings for the ARM-style control unit: instruction classes,
// opcodes, execute command codes and controller state.
package arm_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_DP  = 2'b00,
    MODE_MEM = 2'b01,
    MODE_BR  = 2'b10,
    MODE_MUL = 2'b11
  } mode_t;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_MVN = 4'b1111;
  localparam logic [3:0] OP_MUL = 4'b0000;

  typedef enum logic [3:0] {
    CMD_NOP = 4'd0,
    CMD_MOV = 4'd1,
    CMD_ADD = 4'd2,
    CMD_ADC = 4'd3,
    CMD_SUB = 4'd4,
    CMD_SBC = 4'd5,
    CMD_AND = 4'd6,
    CMD_ORR = 4'd7,
    CMD_EOR = 4'd8,
    CMD_MVN = 4'd9,
    CMD_MUL = 4'd10
  } cmd_t;

  typedef enum logic {
    IDLE     = 1'b0,
    MUL_BUSY = 1'b1
  } state_t;

  typedef struct packed {
    cmd_t cmd;
    logic mem_r;
    logic mem_w;
    logic wb;
    logic b;
    logic s;
    logic undef;
  } ctrl_out_t;

  typedef struct packed {
    ctrl_out_t ctl;
    logic      is_mul;
  } ctrl_t;

endpackage

// File: rtl/ctrl_decode.sv
// Purely combinational opcode-to-control decode; undefined encodings
// resolve to an all-zero command with the undef flag set.
module ctrl_decode
  import arm_ctrl_pkg::*;
#(
  parameter int EN_MUL = 1
) (
  input  logic [1:0] mode,
  input  logic [3:0] opcode,
  input  logic       s_in,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (mode)
      MODE_DP: begin
        ctrl.ctl.wb = 1'b1;
        ctrl.ctl.s  = s_in;
        case (opcode)
          OP_MOV: ctrl.ctl.cmd = CMD_MOV;
          OP_ADD: ctrl.ctl.cmd = CMD_ADD;
          OP_ADC: ctrl.ctl.cmd = CMD_ADC;
          OP_SUB: ctrl.ctl.cmd = CMD_SUB;
          OP_SBC: ctrl.ctl.cmd = CMD_SBC;
          OP_AND: ctrl.ctl.cmd = CMD_AND;
          OP_ORR: ctrl.ctl.cmd = CMD_ORR;
          OP_EOR: ctrl.ctl.cmd = CMD_EOR;
          OP_MVN: ctrl.ctl.cmd = CMD_MVN;
          // Compare/test only set flags; without S they degrade to a bubble.
          OP_CMP: begin
            ctrl.ctl = '0;
            if (s_in) begin
              ctrl.ctl.cmd = CMD_SUB;
              ctrl.ctl.s   = 1'b1;
            end
          end
          OP_TST: begin
            ctrl.ctl = '0;
            if (s_in) begin
              ctrl.ctl.cmd = CMD_AND;
              ctrl.ctl.s   = 1'b1;
            end
          end
          default: begin
            ctrl.ctl       = '0;
            ctrl.ctl.undef = 1'b1;
          end
        endcase
      end
      MODE_MEM: begin
        ctrl.ctl.cmd = CMD_ADD;
        if (s_in) begin
          ctrl.ctl.mem_r = 1'b1;
          ctrl.ctl.wb    = 1'b1;
          ctrl.ctl.s     = 1'b1;
        end else begin
          ctrl.ctl.mem_w = 1'b1;
        end
      end
      MODE_BR: ctrl.ctl.b = ~opcode[3];
      default: begin
        if (EN_MUL != 0 && opcode == OP_MUL) begin
          ctrl.ctl.cmd = CMD_MUL;
          ctrl.ctl.wb  = 1'b1;
          ctrl.ctl.s   = s_in;
          ctrl.is_mul  = 1'b1;
        end else begin
          ctrl.ctl.undef = 1'b1;
        end
      end
    endcase
  end

endmodule

// File: rtl/ctrl_unit_seq.sv
// Sequenced control unit: registers decoded controls, stretches MUL over
// MUL_CYCLES cycles, and honours flush/freeze pipeline events.
module ctrl_unit_seq
  import arm_ctrl_pkg::*;
#(
  parameter int CMD_W      = 4,
  parameter int MUL_CYCLES = 3,
  parameter int EN_MUL     = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic [1:0]       mode,
  input  logic [3:0]       opcode,
  input  logic             s_in,
  input  logic             freeze,
  input  logic             flush,
  output logic             ready_out,
  output logic             valid_out,
  output logic [CMD_W-1:0] cmd_exe,
  output logic             mem_r_en,
  output logic             mem_w_en,
  output logic             wb_en,
  output logic             b_out,
  output logic             s_out,
  output logic             undef_out,
  output logic             mul_busy
);

  state_t    state;
  logic [3:0] cnt;
  ctrl_t     dec;
  ctrl_out_t out_q;
  ctrl_out_t mul_q;
  logic      valid_q;

  ctrl_decode #(.EN_MUL(EN_MUL)) u_decode (
    .mode   (mode),
    .opcode (opcode),
    .s_in   (s_in),
    .ctrl   (dec)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      valid_q <= 1'b0;
      out_q   <= '0;
      mul_q   <= '0;
    end else if (flush) begin
      state   <= IDLE;
      cnt     <= '0;
      valid_q <= 1'b0;
      out_q   <= '0;
    end else if (!freeze) begin
      valid_q <= 1'b0;
      out_q   <= '0;
      case (state)
        IDLE: begin
          if (valid_in) begin
            // MUL controls are parked in mul_q and released when cnt expires.
            if (dec.is_mul) begin
              state <= MUL_BUSY;
              cnt   <= 4'(MUL_CYCLES - 2);
              mul_q <= dec.ctl;
            end else begin
              valid_q <= 1'b1;
              out_q   <= dec.ctl;
            end
          end
        end
        MUL_BUSY: begin
          if (cnt != '0) begin
            cnt <= cnt - 4'd1;
          end else begin
            valid_q <= 1'b1;
            out_q   <= mul_q;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ready_out = (state == IDLE);
  assign mul_busy  = (state == MUL_BUSY);
  assign valid_out = valid_q;
  assign cmd_exe   = CMD_W'(out_q.cmd);
  assign mem_r_en  = out_q.mem_r;
  assign mem_w_en  = out_q.mem_w;
  assign wb_en     = out_q.wb;
  assign b_out     = out_q.b;
  assign s_out     = out_q.s;
  assign undef_out = out_q.undef;

endmodule

// File: tb/tb_ctrl_unit_seq.sv
// Scoreboard bench for ctrl_unit_seq: stimulus pushes expected outputs, a
// monitor pops and compares whenever valid_out presents a fresh result.
module tb_ctrl_unit_seq;

  localparam int CMD_W = 4;

  typedef struct packed {
    logic       v;
    logic [3:0] cmd;
    logic       mr;
    logic       mw;
    logic       wb;
    logic       b;
    logic       s;
    logic       u;
  } obs_t;

  typedef struct packed {
    logic [1:0] mode;
    logic [3:0] op;
    logic       s;
    obs_t       e;
  } vec_t;

  // Hand-computed expectations: {v, cmd, mr, mw, wb, b, s, u}
  localparam vec_t VECS [19] = '{
    '{2'b00, 4'b0100, 1'b1, '{1'b1, 4'd2,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0}},
    '{2'b00, 4'b1101, 1'b0, '{1'b1, 4'd1,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}},
    '{2'b00, 4'b0101, 1'b0, '{1'b1, 4'd3,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}},
    '{2'b00, 4'b0010, 1'b1, '{1'b1, 4'd4,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0}},
    '{2'b00, 4'b0110, 1'b1, '{1'b1, 4'd5,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0}},
    '{2'b00, 4'b0000, 1'b0, '{1'b1, 4'd6,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}},
    '{2'b00, 4'b1100, 1'b1, '{1'b1, 4'd7,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0}},
    '{2'b00, 4'b0001, 1'b1, '{1'b1, 4'd8,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0}},
    '{2'b00, 4'b1111, 1'b0, '{1'b1, 4'd9,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}},
    '{2'b00, 4'b1010, 1'b0, '{1'b1, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}},
    '{2'b00, 4'b1010, 1'b1, '{1'b1, 4'd4,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}},
    '{2'b00, 4'b1000, 1'b1, '{1'b1, 4'd6,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}},
    '{2'b00, 4'b1000, 1'b0, '{1'b1, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}},
    '{2'b01, 4'b0000, 1'b1, '{1'b1, 4'd2,  1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0}},
    '{2'b01, 4'b0000, 1'b0, '{1'b1, 4'd2,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}},
    '{2'b10, 4'b0000, 1'b0, '{1'b1, 4'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}},
    '{2'b10, 4'b1000, 1'b1, '{1'b1, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}},
    '{2'b11, 4'b0001, 1'b1, '{1'b1, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}},
    '{2'b00, 4'b0011, 1'b1, '{1'b1, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}}
  };

  localparam obs_t E_ADD  = '{1'b1, 4'd2,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  localparam obs_t E_LDR  = '{1'b1, 4'd2,  1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  localparam obs_t E_MUL1 = '{1'b1, 4'd10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  localparam obs_t E_MUL0 = '{1'b1, 4'd10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

  logic             clk = 1'b0;
  logic             rst;
  logic             valid_in;
  logic [1:0]       mode;
  logic [3:0]       opcode;
  logic             s_in;
  logic             freeze;
  logic             flush;
  logic             ready_out;
  logic             valid_out;
  logic [CMD_W-1:0] cmd_exe;
  logic             mem_r_en;
  logic             mem_w_en;
  logic             wb_en;
  logic             b_out;
  logic             s_out;
  logic             undef_out;
  logic             mul_busy;

  int   checks = 0;
  int   errors = 0;
  obs_t expq [$];

  always #5 clk = ~clk;

  ctrl_unit_seq #(
    .CMD_W      (CMD_W),
    .MUL_CYCLES (3),
    .EN_MUL     (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .mode      (mode),
    .opcode    (opcode),
    .s_in      (s_in),
    .freeze    (freeze),
    .flush     (flush),
    .ready_out (ready_out),
    .valid_out (valid_out),
    .cmd_exe   (cmd_exe),
    .mem_r_en  (mem_r_en),
    .mem_w_en  (mem_w_en),
    .wb_en     (wb_en),
    .b_out     (b_out),
    .s_out     (s_out),
    .undef_out (undef_out),
    .mul_busy  (mul_busy)
  );

  function automatic obs_t sample();
    return {valid_out, cmd_exe, mem_r_en, mem_w_en, wb_en, b_out, s_out, undef_out};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // One cycle of stimulus, applied 2 time units after the rising edge.
  task automatic cyc(input logic v, input logic [1:0] m, input logic [3:0] op,
                     input logic s, input logic frz = 1'b0, input logic fl = 1'b0,
                     input logic r = 1'b0);
    @(posedge clk);
    #2;
    valid_in = v;
    mode     = m;
    opcode   = op;
    s_in     = s;
    freeze   = frz;
    flush    = fl;
    rst      = r;
  endtask

  task automatic send(input logic [1:0] m, input logic [3:0] op, input logic s,
                      input obs_t e);
    cyc(1'b1, m, op, s);
    expq.push_back(e);
  endtask

  task automatic idle();
    cyc(1'b0, 2'b00, 4'b0000, 1'b0);
  endtask

  obs_t mon_cur;
  obs_t mon_prev = '0;
  obs_t mon_exp;
  logic mon_pbusy = 1'b0;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      mon_cur = sample();
      if (rst) begin
        chk("reset_outputs", 32'(mon_cur), 32'd0);
        chk("reset_ready", 32'(ready_out), 32'd1);
        chk("reset_mul_busy", 32'(mul_busy), 32'd0);
      end else if (freeze && !flush) begin
        chk("freeze_hold", 32'({mon_cur, mul_busy}), 32'({mon_prev, mon_pbusy}));
      end else if (mon_cur.v) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output actual=%0h required=no_output", mon_cur);
        end else begin
          mon_exp = expq.pop_front();
          chk("scoreboard", 32'(mon_cur), 32'(mon_exp));
        end
      end else begin
        chk("bubble_zero", 32'(mon_cur), 32'd0);
      end
      mon_prev  = mon_cur;
      mon_pbusy = mul_busy;
    end
  end

  initial begin
    rst = 1'b1; valid_in = 1'b0; mode = 2'b00; opcode = 4'b0000;
    s_in = 1'b0; freeze = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    idle();
    chk("ready_after_reset", 32'(ready_out), 32'd1);

    foreach (VECS[i]) send(VECS[i].mode, VECS[i].op, VECS[i].s, VECS[i].e);
    idle();
    chk("undef_pulse_high", 32'(undef_out), 32'd1);
    idle();
    chk("undef_pulse_low", 32'(undef_out), 32'd0);

    // MUL latency with MUL_CYCLES=3
    send(2'b11, 4'b0000, 1'b1, E_MUL1);
    idle();
    chk("mul_t1_ready", 32'(ready_out), 32'd0);
    chk("mul_t1_valid", 32'(valid_out), 32'd0);
    chk("mul_t1_busy", 32'(mul_busy), 32'd1);
    idle();
    chk("mul_t2_ready", 32'(ready_out), 32'd0);
    chk("mul_t2_valid", 32'(valid_out), 32'd0);
    idle();
    chk("mul_t3_ready", 32'(ready_out), 32'd1);
    chk("mul_t3_cmd", 32'({valid_out, cmd_exe, wb_en}), 32'({1'b1, 4'd10, 1'b1}));

    // LDR held behind freeze while the previous ADD result is on the outputs
    send(2'b00, 4'b0100, 1'b1, E_ADD);
    for (int k = 0; k < 4; k++) begin
      cyc(1'b1, 2'b01, 4'b0000, 1'b1, 1'b1);
      chk("freeze_busy", 32'(mul_busy), 32'd0);
    end
    send(2'b01, 4'b0000, 1'b1, E_LDR);
    idle();
    chk("resume_ldr", 32'({valid_out, cmd_exe, mem_r_en}), 32'({1'b1, 4'd2, 1'b1}));

    // freeze during MUL_BUSY stretches the latency by the frozen cycles
    send(2'b11, 4'b0000, 1'b0, E_MUL0);
    cyc(1'b0, 2'b00, 4'b0000, 1'b0, 1'b1);
    chk("mulfrz_busy_a", 32'(mul_busy), 32'd1);
    cyc(1'b0, 2'b00, 4'b0000, 1'b0, 1'b1);
    chk("mulfrz_busy_b", 32'(mul_busy), 32'd1);
    idle();
    chk("mulfrz_busy_c", 32'(mul_busy), 32'd1);
    idle();
    chk("mulfrz_valid_d", 32'({valid_out, mul_busy}), 32'({1'b0, 1'b1}));
    idle();
    chk("mulfrz_done", 32'({valid_out, cmd_exe, mul_busy}), 32'({1'b1, 4'd10, 1'b0}));

    // flush in IDLE: the presented instruction is not accepted
    cyc(1'b1, 2'b00, 4'b0100, 1'b1, 1'b0, 1'b1);
    idle();
    chk("flush_idle_valid", 32'(valid_out), 32'd0);

    // flush at T+1 of a MUL aborts it
    cyc(1'b1, 2'b11, 4'b0000, 1'b1);
    cyc(1'b0, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b1);
    chk("flush_mul_busy", 32'(mul_busy), 32'd1);
    idle();
    chk("flush_mul_t2", 32'({valid_out, mul_busy, ready_out}), 32'({1'b0, 1'b0, 1'b1}));
    repeat (4) idle();

    // reset mid-MUL abandons it
    cyc(1'b1, 2'b11, 4'b0000, 1'b1);
    cyc(1'b0, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("rst_mul_busy", 32'(mul_busy), 32'd1);
    idle();
    chk("rst_mul_outs", 32'({sample(), mul_busy, ready_out}), 32'({10'd0, 1'b0, 1'b1}));
    repeat (4) idle();

    chk("queue_empty", 32'(expq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
